// File: rtl/imu_sample_packer_if.sv
// Buses around the IMU sample packer.
//   imu_byte_if   : raw byte stream from the IMU reader (no backpressure).
//     valid        byte qualifier
//     data         burst byte, big-endian within each 16b word
//     frame_start  marks data as byte 0 of a burst
//   imu_sample_if : packed sample toward the filter core, plus packer status.
//     valid        packed sample held
//     ready        core accepts the sample
//     a_x/a_y/a_z  packed accel, two's complement
//     w_x/w_y/w_z  packed gyro, two's complement
//     overrun_cnt  samples dropped while the holding register was full
//     frame_err    1-cycle pulse when a burst restarts before its last byte
// The master modport is the producing side of each bus.

interface imu_byte_if;
  logic       valid;
  logic [7:0] data;
  logic       frame_start;

  modport master (output valid, output data, output frame_start);
  modport slave  (input  valid, input  data, input  frame_start);
endinterface

interface imu_sample_if #(
  parameter int unsigned ACC_WIDTH  = 11,
  parameter int unsigned GYRO_WIDTH = 14
);
  logic                  valid;
  logic                  ready;
  logic [ACC_WIDTH-1:0]  a_x;
  logic [ACC_WIDTH-1:0]  a_y;
  logic [ACC_WIDTH-1:0]  a_z;
  logic [GYRO_WIDTH-1:0] w_x;
  logic [GYRO_WIDTH-1:0] w_y;
  logic [GYRO_WIDTH-1:0] w_z;
  logic [7:0]            overrun_cnt;
  logic                  frame_err;

  modport master (
    output valid, input ready,
    output a_x, output a_y, output a_z,
    output w_x, output w_y, output w_z,
    output overrun_cnt, output frame_err
  );
  modport slave (
    input valid, output ready,
    input a_x, input a_y, input a_z,
    input w_x, input w_y, input w_z,
    input overrun_cnt, input frame_err
  );
endinterface

// File: rtl/imu_sample_packer.sv
// Packs the 14-byte big-endian IMU burst (AX,AY,AZ,TEMP,GX,GY,GZ) into one
// shifted and saturated sample and offers it to the Madgwick core through a
// 1-deep holding register. New samples arriving while the register is still
// full are dropped and counted.
// Ports:
//   clk     system clock
//   rst_n   synchronous reset, active low
//   burst   imu_byte_if.slave     raw byte stream
//   sample  imu_sample_if.master  packed sample, handshake and status

module imu_sample_packer #(
  parameter int unsigned ACC_WIDTH  = 11,
  parameter int unsigned GYRO_WIDTH = 14,
  parameter int unsigned ACC_SHIFT  = 5,
  parameter int unsigned GYRO_SHIFT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  imu_byte_if.slave    burst,
  imu_sample_if.master sample
);

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned CNT_W    = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(13);
  localparam int ACC_MAX  = (1 <<< (ACC_WIDTH - 1)) - 1;
  localparam int ACC_MIN  = -(1 <<< (ACC_WIDTH - 1));
  localparam int GYRO_MAX = (1 <<< (GYRO_WIDTH - 1)) - 1;
  localparam int GYRO_MIN = -(1 <<< (GYRO_WIDTH - 1));

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [15:0]        ax_q, ay_q, az_q, gx_q, gy_q;
  logic [7:0]         gz_hi_q;

  logic               accept;
  logic               start_c, store_c, complete_c, frame_err_c;
  logic [IDX_W-1:0]   wr_idx;
  logic               xfer;

  logic                  valid_q;
  logic [ACC_WIDTH-1:0]  a_x_q, a_y_q, a_z_q;
  logic [GYRO_WIDTH-1:0] w_x_q, w_y_q, w_z_q;
  logic [CNT_W-1:0]      overrun_q;
  logic                  frame_err_q;

  logic [ACC_WIDTH-1:0]  a_x_c, a_y_c, a_z_c;
  logic [GYRO_WIDTH-1:0] w_x_c, w_y_c, w_z_c;

  // Arithmetic shift of a raw 16b word, then clamp into ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] pack_acc(input logic [15:0] raw);
    int t;
    t = int'($signed(raw)) >>> ACC_SHIFT;
    if (t > ACC_MAX)      return ACC_WIDTH'(ACC_MAX);
    else if (t < ACC_MIN) return ACC_WIDTH'(ACC_MIN);
    else                  return ACC_WIDTH'(t);
  endfunction

  // Arithmetic shift of a raw 16b word, then clamp into GYRO_WIDTH.
  function automatic logic [GYRO_WIDTH-1:0] pack_gyro(input logic [15:0] raw);
    int t;
    t = int'($signed(raw)) >>> GYRO_SHIFT;
    if (t > GYRO_MAX)      return GYRO_WIDTH'(GYRO_MAX);
    else if (t < GYRO_MIN) return GYRO_WIDTH'(GYRO_MIN);
    else                   return GYRO_WIDTH'(t);
  endfunction

  assign accept = burst.valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && burst.frame_start) state_d = COLLECT;
      end
      COLLECT: begin
        if (accept && !burst.frame_start && (idx_q == LAST_IDX)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM strobes. A frame_start mid-burst restarts collection at byte 0.
  always_comb begin
    start_c     = 1'b0;
    store_c     = 1'b0;
    complete_c  = 1'b0;
    frame_err_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && burst.frame_start) start_c = 1'b1;
      end
      COLLECT: begin
        if (accept) begin
          if (burst.frame_start) begin
            start_c     = 1'b1;
            frame_err_c = 1'b1;
          end else begin
            store_c = 1'b1;
            if (idx_q == LAST_IDX) complete_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign wr_idx = start_c ? '0 : idx_q;

  // Byte index: next slot to be filled.
  always_ff @(posedge clk) begin
    if (!rst_n)          idx_q <= '0;
    else if (start_c)    idx_q <= IDX_W'(1);
    else if (complete_c) idx_q <= '0;
    else if (store_c)    idx_q <= IDX_W'(idx_q + IDX_W'(1));
  end

  // Raw shadow registers. TEMP bytes are dropped; the GZ low byte is never
  // stored because it is consumed straight off the bus at completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ax_q    <= '0;
      ay_q    <= '0;
      az_q    <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      gz_hi_q <= '0;
    end else if (start_c || store_c) begin
      case (wr_idx[3:1])
        3'd0: if (wr_idx[0]) ax_q[7:0] <= burst.data; else ax_q[15:8] <= burst.data;
        3'd1: if (wr_idx[0]) ay_q[7:0] <= burst.data; else ay_q[15:8] <= burst.data;
        3'd2: if (wr_idx[0]) az_q[7:0] <= burst.data; else az_q[15:8] <= burst.data;
        3'd4: if (wr_idx[0]) gx_q[7:0] <= burst.data; else gx_q[15:8] <= burst.data;
        3'd5: if (wr_idx[0]) gy_q[7:0] <= burst.data; else gy_q[15:8] <= burst.data;
        3'd6: if (!wr_idx[0]) gz_hi_q <= burst.data;
        default: ;
      endcase
    end
  end

  // Conversion of the completed burst.
  always_comb begin
    a_x_c = pack_acc(ax_q);
    a_y_c = pack_acc(ay_q);
    a_z_c = pack_acc(az_q);
    w_x_c = pack_gyro(gx_q);
    w_y_c = pack_gyro(gy_q);
    w_z_c = pack_gyro({gz_hi_q, burst.data});
  end

  assign xfer = valid_q && sample.ready;

  // Holding register: loads when empty or being drained this cycle,
  // otherwise the new sample is dropped and counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      a_x_q     <= '0;
      a_y_q     <= '0;
      a_z_q     <= '0;
      w_x_q     <= '0;
      w_y_q     <= '0;
      w_z_q     <= '0;
      overrun_q <= '0;
    end else if (complete_c && (!valid_q || xfer)) begin
      valid_q <= 1'b1;
      a_x_q   <= a_x_c;
      a_y_q   <= a_y_c;
      a_z_q   <= a_z_c;
      w_x_q   <= w_x_c;
      w_y_q   <= w_y_c;
      w_z_q   <= w_z_c;
    end else if (complete_c) begin
      if (overrun_q != '1) overrun_q <= CNT_W'(overrun_q + CNT_W'(1));
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  // Restart pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_c;
  end

  assign sample.valid       = valid_q;
  assign sample.a_x         = a_x_q;
  assign sample.a_y         = a_y_q;
  assign sample.a_z         = a_z_q;
  assign sample.w_x         = w_x_q;
  assign sample.w_y         = w_y_q;
  assign sample.w_z         = w_z_q;
  assign sample.overrun_cnt = overrun_q;
  assign sample.frame_err   = frame_err_q;

endmodule
